// File: rtl/uart_rsa_pkg.sv
// Shared types and helpers for the UART-to-RSA operand path.
package uart_rsa_pkg;

    localparam int UART_FRAME_BITS = 10;

    typedef enum logic {
        ASM_IDLE = 1'b0,
        ASM_FILL = 1'b1
    } asm_state_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Clock cycles occupied by one start + 8 data + stop frame on the line.
    function automatic int cycles_per_byte(input int clk_hz, input int bit_rate);
        return UART_FRAME_BITS * (clk_hz / bit_rate);
    endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Inter-byte idle timer: reloads on clr, counts down while run, flags terminal count.
module rx_idle_timer #(
    parameter int CYCLES = 200
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] remaining;

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            remaining <= W'(CYCLES);
        end else if (run && remaining != '0) begin
            remaining <= remaining - W'(1);
        end
    end

    // Drops with run, since the collector leaves ASM_FILL on expiry.
    assign expired = run && (remaining == '0);

endmodule

// File: rtl/uart_word_assembler.sv
// Packs UART bytes big-endian into wide words behind a one-deep output buffer.
// Optional inter-byte timeout is enabled by defining UART_ASM_TIMEOUT_EN.
//
// state     | meaning
// ASM_IDLE  | no partial word held, byte_cnt == 0
// ASM_FILL  | partial word held, 0 < byte_cnt < WORD_BYTES
// OUT_EMPTY | no word offered, word_valid = 0
// OUT_FULL  | word_data offered, word_valid = 1
module uart_word_assembler
    import uart_rsa_pkg::*;
#(
    parameter int PAYLOAD_BITS  = 8,
    parameter int WORD_BYTES    = 4,
    parameter int CLK_HZ        = 100_000_000,
    parameter int BIT_RATE      = 9600,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               byte_valid,
    input  logic [PAYLOAD_BITS-1:0]            byte_data,
    input  logic                               byte_break,
    output logic                               word_valid,
    input  logic                               word_ready,
    output logic [WORD_BYTES*PAYLOAD_BITS-1:0] word_data,
    output logic                               word_overrun,
    output logic                               word_timeout
);

    localparam int WORD_W         = WORD_BYTES * PAYLOAD_BITS;
    localparam int CNT_W          = $clog2(WORD_BYTES + 1);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * cycles_per_byte(CLK_HZ, BIT_RATE);

    asm_state_t        asm_state;
    out_state_t        out_state;
    logic [CNT_W-1:0]  byte_cnt;
    logic [CNT_W-1:0]  eff_cnt;
    logic [WORD_W-1:0] asm_reg;
    logic [WORD_W-1:0] next_word;
    logic              byte_accept;
    logic              byte_brk;
    logic              word_done;
    logic              timeout_hit;

`ifdef UART_ASM_TIMEOUT_EN
    rx_idle_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (byte_valid),
        .run     (asm_state == ASM_FILL),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // A byte landing on the timeout cycle starts a fresh word, hence eff_cnt.
    always_comb begin
        byte_accept = byte_valid && !byte_break;
        byte_brk    = byte_valid && byte_break;
        eff_cnt     = (timeout_hit || asm_state == ASM_IDLE) ? '0 : byte_cnt;
        next_word   = (eff_cnt == '0) ? WORD_W'(byte_data)
                                      : {asm_reg[WORD_W-PAYLOAD_BITS-1:0], byte_data};
        word_done   = byte_accept && (eff_cnt == CNT_W'(WORD_BYTES - 1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            asm_state    <= ASM_IDLE;
            byte_cnt     <= '0;
            asm_reg      <= '0;
            word_timeout <= 1'b0;
        end else begin
            word_timeout <= timeout_hit;
            if (byte_brk || word_done || (timeout_hit && !byte_accept)) begin
                asm_state <= ASM_IDLE;
                byte_cnt  <= '0;
                asm_reg   <= '0;
            end else if (byte_accept) begin
                asm_state <= ASM_FILL;
                byte_cnt  <= eff_cnt + CNT_W'(1);
                asm_reg   <= next_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_state    <= OUT_EMPTY;
            word_data    <= '0;
            word_overrun <= 1'b0;
        end else begin
            word_overrun <= 1'b0;
            case (out_state)
                OUT_EMPTY: begin
                    if (word_done) begin
                        word_data <= next_word;
                        out_state <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (word_done) begin
                        // Consumer taking the old word this cycle frees the slot.
                        if (word_ready) begin
                            word_data <= next_word;
                        end else begin
                            word_overrun <= 1'b1;
                        end
                    end else if (word_ready) begin
                        out_state <= OUT_EMPTY;
                    end
                end
                default: out_state <= OUT_EMPTY;
            endcase
        end
    end

    assign word_valid = (out_state == OUT_FULL);

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed self-checking bench for uart_word_assembler (WORD_BYTES=4, 200-cycle timeout).
module tb_uart_word_assembler;

    logic        clk = 1'b0;
    logic        resetn;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_break;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic        word_overrun;
    logic        word_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    uart_word_assembler #(
        .PAYLOAD_BITS  (8),
        .WORD_BYTES    (4),
        .CLK_HZ        (1_000_000),
        .BIT_RATE      (100_000),
        .TIMEOUT_BYTES (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_break   (byte_break),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_data    (word_data),
        .word_overrun (word_overrun),
        .word_timeout (word_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200_000;
        $display("FAIL watchdog: observed no end of test, expected end before 200us");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic brk);
        byte_valid = 1'b1;
        byte_data  = b;
        byte_break = brk;
        step();
        byte_valid = 1'b0;
        byte_break = 1'b0;
    endtask

    initial begin
        int to_pulses;
        int to_cycle;

        resetn     = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_break = 1'b0;
        word_ready = 1'b0;
        step();
        step();
        check("reset_valid",   word_valid,   1'b0);
        check("reset_data",    word_data,    32'h0);
        check("reset_overrun", word_overrun, 1'b0);
        check("reset_timeout", word_timeout, 1'b0);
        resetn = 1'b1;
        step();

        // Basic word
        word_ready = 1'b1;
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        check("basic_partial_valid", word_valid, 1'b0);
        send_byte(8'hEF, 1'b0);
        check("basic_valid", word_valid, 1'b1);
        check("basic_data",  word_data,  32'hDEADBEEF);
        step();
        check("basic_one_cycle", word_valid, 1'b0);

        // Break resync
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h00, 1'b1);
        check("break_no_word", word_valid, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        check("break_partial_valid", word_valid, 1'b0);
        send_byte(8'h44, 1'b0);
        check("break_valid", word_valid, 1'b1);
        check("break_data",  word_data,  32'h11223344);
        step();
        check("break_drained", word_valid, 1'b0);

        // Overrun
        word_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        check("ovr_first_valid", word_valid, 1'b1);
        check("ovr_first_data",  word_data,  32'h01020304);
        for (int i = 5; i <= 7; i++) send_byte(8'(i), 1'b0);
        check("ovr_pre_pulse", word_overrun, 1'b0);
        send_byte(8'h08, 1'b0);
        check("ovr_pulse",     word_overrun, 1'b1);
        check("ovr_held_data", word_data,    32'h01020304);
        check("ovr_held_valid", word_valid,  1'b1);
        step();
        check("ovr_pulse_end", word_overrun, 1'b0);
        word_ready = 1'b1;
        step();
        check("ovr_accepted", word_valid, 1'b0);
        step();
        step();
        check("ovr_single_word", word_valid, 1'b0);

        // Completion and handshake in the same cycle
        word_ready = 1'b0;
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h23, 1'b0);
        send_byte(8'h24, 1'b0);
        check("sim_first_data", word_data, 32'h21222324);
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b0);
        word_ready = 1'b1;
        send_byte(8'h34, 1'b0);
        check("sim_second_valid", word_valid,   1'b1);
        check("sim_second_data",  word_data,    32'h31323334);
        check("sim_no_overrun",   word_overrun, 1'b0);
        step();
        check("sim_drained",         word_valid,   1'b0);
        check("sim_no_overrun_late", word_overrun, 1'b0);

        // Inter-byte timeout
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        to_pulses = 0;
        to_cycle  = 0;
        for (int i = 1; i <= 260; i++) begin
            step();
            if (word_timeout) begin
                to_pulses++;
                to_cycle = i;
            end
        end
        check("to_no_word", word_valid, 1'b0);
`ifdef UART_ASM_TIMEOUT_EN
        check("to_pulses", to_pulses, 1);
        check("to_cycle",  to_cycle,  201);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        check("to_valid", word_valid, 1'b1);
        check("to_data",  word_data,  32'h01020304);
        step();
`else
        check("to_pulses", to_pulses, 0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        check("to_valid", word_valid, 1'b1);
        check("to_data",  word_data,  32'hAABB0102);
        step();
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
`endif
        check("to_drained", word_valid, 1'b0);

        // Reset mid-word, with a held word and a partial word in flight
        send_byte(8'h00, 1'b1);
        word_ready = 1'b0;
        send_byte(8'h91, 1'b0);
        send_byte(8'h92, 1'b0);
        send_byte(8'h93, 1'b0);
        send_byte(8'h94, 1'b0);
        check("rst_held_data", word_data, 32'h91929394);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        resetn = 1'b0;
        step();
        check("rst_valid",   word_valid,   1'b0);
        check("rst_data",    word_data,    32'h0);
        check("rst_overrun", word_overrun, 1'b0);
        check("rst_timeout", word_timeout, 1'b0);
        step();
        check("rst_valid2", word_valid, 1'b0);
        check("rst_data2",  word_data,  32'h0);
        resetn     = 1'b1;
        word_ready = 1'b1;
        send_byte(8'hCA, 1'b0);
        send_byte(8'hFE, 1'b0);
        send_byte(8'hF0, 1'b0);
        check("rst_partial_valid", word_valid, 1'b0);
        send_byte(8'h0D, 1'b0);
        check("rst_word_valid", word_valid, 1'b1);
        check("rst_word_data",  word_data,  32'hCAFEF00D);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
